// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Sequencer between the module-image loader, a byte-addressed ring memory
// (the instruction window) and the WASM decoder. Loader chunks are streamed
// into the memory write window while a shadow occupancy counter tracks the
// unread bytes. The read window is offered to the decoder only when enough
// bytes are resident (a full RD_WIN, or whatever remains once the image has
// been completely loaded). Overwrite of unread bytes is prevented through
// ld_rdy, over-consumption is refused and flagged, and done is raised once
// the whole image has been consumed.
//
// Handshake semantics (all three interfaces): a transfer happens in a cycle
// where the producer's valid and the consumer's ready/accept condition are
// both high at the rising clock edge. valid may be raised or dropped freely
// and is not required to wait for ready; ready never depends combinationally
// on the same interface's valid or payload.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               pulse, begin a new image (honoured in IDLE/DONE only)
//   ld_vld/ld_rdy       loader chunk handshake
//   ld_data, ld_cnt_m1  chunk bytes (byte 0 in [7:0]) and byte count - 1
//   ld_last             chunk is the final one of the image
//   mem_we, mem_wr_*    write strobe, advance - 1 and bytes to the memory
//   mem_re, mem_rd_data memory read enable and read window
//   mem_shift_vld,      read-pointer advance strobe and advance - 1
//   mem_rd_shift_m1
//   win_vld, win_data   window valid / bytes to the decoder
//   win_avail           resident unread bytes
//   dec_shift_vld,      decoder consume strobe and byte count - 1
//   dec_shift_m1
//   busy, done          state is LOAD/RUN, image fully consumed
//   err_ovr             sticky: decoder asked for more than was resident
//   stall_cnt           decoder-stall cycle counter
//   state_dbg           current FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
//
// Build option
//   INSTR_FETCH_STALL_CNT_EN : when defined, stall_cnt counts (saturating)
//   cycles spent in RUN with no window offered while the loader is still
//   expected to deliver. When undefined, stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int RD_WIN     = 8,
    parameter int WR_WIN     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          ld_vld,
    output logic                          ld_rdy,
    input  logic [WR_WIN*8-1:0]           ld_data,
    input  logic [$clog2(WR_WIN)-1:0]     ld_cnt_m1,
    input  logic                          ld_last,
    output logic                          mem_we,
    output logic [$clog2(WR_WIN)-1:0]     mem_wr_shift_m1,
    output logic [WR_WIN*8-1:0]           mem_wr_data,
    output logic                          mem_re,
    input  logic [RD_WIN*8-1:0]           mem_rd_data,
    output logic                          mem_shift_vld,
    output logic [$clog2(RD_WIN):0]       mem_rd_shift_m1,
    output logic                          win_vld,
    output logic [RD_WIN*8-1:0]           win_data,
    output logic [ADDR_WIDTH:0]           win_avail,
    input  logic                          dec_shift_vld,
    input  logic [$clog2(RD_WIN):0]       dec_shift_m1,
    output logic                          busy,
    output logic                          done,
    output logic                          err_ovr,
    output logic [15:0]                   stall_cnt,
    output logic [1:0]                    state_dbg
);

    localparam int OW = ADDR_WIDTH + 1;
    localparam logic [OW-1:0] DEPTH = OW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            ld_done_q, ld_done_d;
    logic            err_ovr_q;

    logic [OW-1:0]   free;
    logic [OW-1:0]   w_n, r_n;
    logic            wr_acc, rd_acc, rd_ovr;
    logic            restart;

    // start is only honoured from a quiescent state.
    assign restart = start & ((state_q == IDLE) | (state_q == DONE));

    // Occupancy arithmetic. The consume check uses the pre-update occupancy,
    // so bytes written in the same cycle cannot be consumed yet.
    always_comb begin
        free      = DEPTH - occ_q;
        w_n       = OW'(ld_cnt_m1) + OW'(1);
        r_n       = OW'(dec_shift_m1) + OW'(1);
        occ_d     = occ_q + (wr_acc ? w_n : '0) - (rd_acc ? r_n : '0);
        ld_done_d = ld_done_q | (wr_acc & ld_last);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: if ((occ_d >= OW'(RD_WIN)) || (wr_acc && ld_last)) state_d = RUN;
            RUN:  if (ld_done_q && (occ_d == '0)) state_d = DONE;
            DONE: if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: strobes and buses are driven only while they carry a
    // transfer, so everything reads zero in IDLE/DONE and out of reset.
    always_comb begin
        busy            = (state_q == LOAD) | (state_q == RUN);
        done            = (state_q == DONE);
        ld_rdy          = busy & ~ld_done_q & (free >= OW'(WR_WIN));
        wr_acc          = ld_vld & ld_rdy;
        // Once the image is fully loaded a short tail window is acceptable.
        win_vld         = (state_q == RUN) &
                          ((occ_q >= OW'(RD_WIN)) | (ld_done_q & (occ_q != '0)));
        rd_acc          = dec_shift_vld & win_vld & (r_n <= occ_q);
        rd_ovr          = dec_shift_vld & win_vld & (r_n > occ_q);
        mem_we          = wr_acc;
        mem_wr_shift_m1 = wr_acc ? ld_cnt_m1 : '0;
        mem_wr_data     = wr_acc ? ld_data : '0;
        mem_re          = win_vld;
        win_data        = win_vld ? mem_rd_data : '0;
        win_avail       = occ_q;
        mem_shift_vld   = rd_acc;
        mem_rd_shift_m1 = rd_acc ? dec_shift_m1 : '0;
        err_ovr         = err_ovr_q;
        state_dbg       = state_q;
    end

    // Occupancy and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= '0;
            ld_done_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else if (restart) begin
            occ_q     <= '0;
            ld_done_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            ld_done_q <= ld_done_d;
            if (rd_ovr) err_ovr_q <= 1'b1;
        end
    end

`ifdef INSTR_FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    // A stall is a RUN cycle where the decoder has no window and the loader
    // still owes data (after ld_done a short window is always offered).
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && !win_vld && !ld_done_q &&
                     (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
//
// Directed bench for instr_fetch_ctrl (ADDR_WIDTH=8, RD_WIN=8, WR_WIN=4).
// A small ring-memory model sits on the memory ports; loaded bytes are queued
// in exp_q and the first window byte is compared on every consume.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        ld_vld = 1'b0;
    logic        ld_rdy;
    logic [31:0] ld_data = '0;
    logic [1:0]  ld_cnt_m1 = '0;
    logic        ld_last = 1'b0;
    logic        mem_we;
    logic [1:0]  mem_wr_shift_m1;
    logic [31:0] mem_wr_data;
    logic        mem_re;
    logic [63:0] mem_rd_data;
    logic        mem_shift_vld;
    logic [3:0]  mem_rd_shift_m1;
    logic        win_vld;
    logic [63:0] win_data;
    logic [8:0]  win_avail;
    logic        dec_shift_vld = 1'b0;
    logic [3:0]  dec_shift_m1 = '0;
    logic        busy;
    logic        done;
    logic        err_ovr;
    logic [15:0] stall_cnt;
    logic [1:0]  state_dbg;

    instr_fetch_ctrl #(.ADDR_WIDTH(8), .RD_WIN(8), .WR_WIN(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_data(ld_data),
        .ld_cnt_m1(ld_cnt_m1), .ld_last(ld_last),
        .mem_we(mem_we), .mem_wr_shift_m1(mem_wr_shift_m1), .mem_wr_data(mem_wr_data),
        .mem_re(mem_re), .mem_rd_data(mem_rd_data),
        .mem_shift_vld(mem_shift_vld), .mem_rd_shift_m1(mem_rd_shift_m1),
        .win_vld(win_vld), .win_data(win_data), .win_avail(win_avail),
        .dec_shift_vld(dec_shift_vld), .dec_shift_m1(dec_shift_m1),
        .busy(busy), .done(done), .err_ovr(err_ovr),
        .stall_cnt(stall_cnt), .state_dbg(state_dbg)
    );

    // ---------------- ring memory model ----------------
    logic [7:0] mem [0:255];
    logic [7:0] wp = '0;
    logic [7:0] rp = '0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (i <= int'(mem_wr_shift_m1)) mem[wp + 8'(i)] <= mem_wr_data[8*i +: 8];
                wp <= wp + 8'(mem_wr_shift_m1) + 8'd1;
            end
            if (mem_shift_vld) rp <= rp + 8'(mem_rd_shift_m1) + 8'd1;
        end
    end

    always_comb begin
        mem_rd_data = '0;
        for (int i = 0; i < 8; i++) mem_rd_data[8*i +: 8] = mem[rp + 8'(i)];
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int seed     = 8'h10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_chunk(input int n, input bit last);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = 8'(seed + i);
        ld_data = d; ld_cnt_m1 = 2'(n - 1); ld_last = last; ld_vld = 1'b1;
        #1;
        check("ld_accept", 32'(mem_we), 32'd1);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(seed + i));
        seed += n;
        tick();
        ld_vld = 1'b0; ld_last = 1'b0;
    endtask

    task automatic consume(input int n);
        dec_shift_vld = 1'b1; dec_shift_m1 = 4'(n - 1);
        #1;
        check("rd_accept", 32'(mem_shift_vld), 32'd1);
        check("win_byte0", 32'(win_data[7:0]), 32'(exp_q.size() > 0 ? exp_q[0] : 8'h00));
        repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_front());
        tick();
        dec_shift_vld = 1'b0;
    endtask

    int stall_exp;

    // ---------------- directed sequence ----------------
    initial begin
`ifdef INSTR_FETCH_STALL_CNT_EN
        stall_exp = 5;
`else
        stall_exp = 0;
`endif
        tick();
        tick();
        // reset state (rst still high)
        check("rst_ld_rdy",  32'(ld_rdy), 0);
        check("rst_mem_we",  32'(mem_we), 0);
        check("rst_mem_re",  32'(mem_re), 0);
        check("rst_shift",   32'(mem_shift_vld), 0);
        check("rst_win_vld", 32'(win_vld), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_done",    32'(done), 0);
        check("rst_err",     32'(err_ovr), 0);
        check("rst_stall",   32'(stall_cnt), 0);
        check("rst_avail",   32'(win_avail), 0);
        check("rst_wdata",   mem_wr_data, 0);
        check("rst_state",   32'(state_dbg), 0);
        rst = 1'b0;
        tick();

        // ---- 52-byte image in 13 chunks ----
        pulse_start();
        check("t1_state_load", 32'(state_dbg), 1);
        check("t1_ld_rdy", 32'(ld_rdy), 1);
        send_chunk(4, 1'b0);
        check("t1_c1_state", 32'(state_dbg), 1);
        check("t1_c1_win_vld", 32'(win_vld), 0);
        check("t1_c1_avail", 32'(win_avail), 4);
        send_chunk(4, 1'b0);
        check("t1_c2_state", 32'(state_dbg), 2);
        check("t1_c2_win_vld", 32'(win_vld), 1);
        check("t1_c2_mem_re", 32'(mem_re), 1);
        check("t1_c2_avail", 32'(win_avail), 8);
        for (int k = 3; k <= 12; k++) send_chunk(4, 1'b0);
        send_chunk(4, 1'b1);
        check("t1_avail52", 32'(win_avail), 52);
        check("t1_ld_rdy_done", 32'(ld_rdy), 0);
        ld_vld = 1'b1;
        #1;
        check("t1_no_accept_after_last", 32'(mem_we), 0);
        ld_vld = 1'b0;
        repeat (6) consume(8);
        check("t1_tail_avail", 32'(win_avail), 4);
        check("t1_tail_win_vld", 32'(win_vld), 1);
        consume(4);
        check("t1_done", 32'(done), 1);
        check("t1_state_done", 32'(state_dbg), 3);
        check("t1_busy", 32'(busy), 0);
        check("t1_win_vld_off", 32'(win_vld), 0);

        // ---- fill the ring ----
        pulse_start();
        check("t2_restart_avail", 32'(win_avail), 0);
        repeat (64) send_chunk(4, 1'b0);
        check("t2_full_avail", 32'(win_avail), 256);
        check("t2_full_ld_rdy", 32'(ld_rdy), 0);
        ld_vld = 1'b1;
        #1;
        check("t2_full_no_we", 32'(mem_we), 0);
        ld_vld = 1'b0;
        consume(8);
        check("t2_ld_rdy_back", 32'(ld_rdy), 1);
        check("t2_avail248", 32'(win_avail), 248);

        // ---- concurrent write and consume at occ=10 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        pulse_start();
        send_chunk(4, 1'b0);
        send_chunk(4, 1'b0);
        send_chunk(2, 1'b0);
        check("t3_avail10", 32'(win_avail), 10);
        ld_data = {8'(seed + 3), 8'(seed + 2), 8'(seed + 1), 8'(seed)};
        ld_cnt_m1 = 2'd3; ld_vld = 1'b1;
        dec_shift_vld = 1'b1; dec_shift_m1 = 4'd2;
        #1;
        check("t3_mem_we", 32'(mem_we), 1);
        check("t3_mem_shift", 32'(mem_shift_vld), 1);
        check("t3_win_byte0", 32'(win_data[7:0]), 32'(exp_q[0]));
        repeat (3) void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(seed + i));
        seed += 4;
        tick();
        ld_vld = 1'b0; dec_shift_vld = 1'b0;
        check("t3_avail11", 32'(win_avail), 11);
        pulse_start();
        check("t3_start_ignored_avail", 32'(win_avail), 11);
        check("t3_start_ignored_state", 32'(state_dbg), 2);

        // ---- starvation, then over-consume with a short tail ----
        consume(8);
        check("t4_avail3", 32'(win_avail), 3);
        check("t4_win_vld_low", 32'(win_vld), 0);
        dec_shift_vld = 1'b1; dec_shift_m1 = 4'd0;
        #1;
        check("t4_ignored_shift", 32'(mem_shift_vld), 0);
        tick();
        dec_shift_vld = 1'b0;
        repeat (4) tick();
        check("t4_no_err_when_invalid", 32'(err_ovr), 0);
        check("t4_stall_cnt", 32'(stall_cnt), 32'(stall_exp));
        send_chunk(4, 1'b1);
        check("t4_tail_win_vld", 32'(win_vld), 1);
        check("t4_avail7", 32'(win_avail), 7);
        consume(4);
        check("t4_avail3_done", 32'(win_avail), 3);
        dec_shift_vld = 1'b1; dec_shift_m1 = 4'd4;
        #1;
        check("t4_ovr_no_shift", 32'(mem_shift_vld), 0);
        tick();
        dec_shift_vld = 1'b0;
        check("t4_err_ovr", 32'(err_ovr), 1);
        check("t4_occ_kept", 32'(win_avail), 3);
        consume(3);
        check("t4_done", 32'(done), 1);
        check("t4_err_sticky", 32'(err_ovr), 1);
        pulse_start();
        check("t4_err_cleared", 32'(err_ovr), 0);
        check("t4_stall_cleared", 32'(stall_cnt), 0);
        check("t4_busy", 32'(busy), 1);

        // ---- reset mid-RUN at occ=20 ----
        repeat (5) send_chunk(4, 1'b0);
        check("t5_avail20", 32'(win_avail), 20);
        check("t5_state_run", 32'(state_dbg), 2);
        rst = 1'b1; ld_vld = 1'b1; dec_shift_vld = 1'b1; dec_shift_m1 = 4'd0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t5_state_idle", 32'(state_dbg), 0);
        check("t5_avail0", 32'(win_avail), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ld_rdy", 32'(ld_rdy), 0);
        check("t5_mem_we", 32'(mem_we), 0);
        check("t5_mem_shift", 32'(mem_shift_vld), 0);
        check("t5_win_vld", 32'(win_vld), 0);
        check("t5_mem_re", 32'(mem_re), 0);
        ld_vld = 1'b0; dec_shift_vld = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound for the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
